// File: rtl/debug_unit.sv
// UART debug controller: program loader, run/step gate and state dump.
// Sits in front of top_pipeline and drives its debug and load ports.
module debug_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_ADDR    = 7,
  parameter int N_REGISTER = 32,
  parameter int N_MEM_DUMP = 32,
  parameter logic [NB_DATA-1:0] HALT_INSTR = {NB_DATA{1'b1}},
  parameter logic [7:0] CMD_LOAD = 8'h4C,
  parameter logic [7:0] CMD_RUN  = 8'h43,
  parameter logic [7:0] CMD_STEP = 8'h53
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_done_i,
  input  logic               tx_done_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               halt_signal_i,
  input  logic [NB_ADDR-1:0] data_pc_debug_i,
  input  logic [NB_DATA-1:0] data_registers_debug_i,
  input  logic [NB_DATA-1:0] data_mem_debug_i,
  output logic               en_pipeline_o,
  output logic               en_read_inst_o,
  output logic [NB_DATA-1:0] inst_data_o,
  output logic               inst_write_o,
  output logic [NB_ADDR-1:0] inst_addr_o,
  output logic               select_debug_or_wireA_o,
  output logic [NB_REG-1:0]  addr_reg_debug_o,
  output logic               select_debug_or_alu_result_o,
  output logic [NB_ADDR-1:0] addr_mem_debug_o,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_WRITE  = 4'd2,
    S_RUN    = 4'd3,
    S_STEP   = 4'd4,
    S_PC     = 4'd5,
    S_SETTLE = 4'd6,
    S_WAIT   = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_PC  = 2'd0,
    PH_REG = 2'd1,
    PH_MEM = 2'd2
  } phase_t;

  localparam logic [NB_REG-1:0]  LAST_REG = NB_REG'(N_REGISTER - 1);
  localparam logic [NB_ADDR-1:0] LAST_MEM = NB_ADDR'(N_MEM_DUMP - 1);
  localparam logic [NB_ADDR-1:0] ADDR_MAX = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] A_ONE    = NB_ADDR'(1);
  localparam logic [NB_REG-1:0]  R_ONE    = NB_REG'(1);

  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic                 halted_q, halted_d;
  logic [1:0]           byte_q, byte_d;
  logic                 hold_q, hold_d;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 en_pipe_q, en_pipe_d;
  logic                 en_read_q, en_read_d;
  logic [NB_DATA-1:0]   inst_data_q, inst_data_d;
  logic                 inst_write_q, inst_write_d;
  logic [NB_ADDR-1:0]   inst_addr_q, inst_addr_d;
  logic                 sel_reg_q, sel_reg_d;
  logic [NB_REG-1:0]    addr_reg_q, addr_reg_d;
  logic                 sel_mem_q, sel_mem_d;
  logic [NB_ADDR-1:0]   addr_mem_q, addr_mem_d;
  logic [NB_DATA-1:0]   cap;
  logic [NB_DATA-1:0]   load_word;

  assign cap = sel_mem_q ? data_mem_debug_i : data_registers_debug_i;
  assign load_word = {word_q[NB_DATA-9:0], rx_data_i};

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    halted_d     = halted_q;
    byte_d       = byte_q;
    hold_d       = hold_q;
    word_d       = word_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    en_pipe_d    = 1'b0;
    inst_data_d  = inst_data_q;
    inst_write_d = 1'b0;
    inst_addr_d  = inst_addr_q;
    sel_reg_d    = sel_reg_q;
    addr_reg_d   = addr_reg_q;
    sel_mem_d    = sel_mem_q;
    addr_mem_d   = addr_mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_done_i) begin
          unique case (1'b1)
            rx_data_i == CMD_LOAD: begin
              state_d     = S_LOAD;
              inst_addr_d = '0;
              byte_d      = '0;
              halted_d    = 1'b0;
            end
            (rx_data_i == CMD_RUN) && !halted_q: begin
              state_d   = S_RUN;
              en_pipe_d = 1'b1;
            end
            (rx_data_i == CMD_STEP) && !halted_q: begin
              state_d   = S_STEP;
              en_pipe_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_done_i) begin
          word_d = load_word;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            state_d      = S_WRITE;
            inst_data_d  = load_word;
            inst_write_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // Top of memory ends the load as well; the address never wraps.
        if (inst_data_q == HALT_INSTR || inst_addr_q == ADDR_MAX) begin
          state_d = S_IDLE;
        end else begin
          inst_addr_d = inst_addr_q + A_ONE;
          state_d     = S_LOAD;
        end
      end
      S_RUN: begin
        if (halt_signal_i) begin
          halted_d = 1'b1;
          state_d  = S_PC;
          phase_d  = PH_PC;
        end else begin
          en_pipe_d = 1'b1;
        end
      end
      S_STEP: begin
        if (halt_signal_i) halted_d = 1'b1;
        state_d = S_PC;
        phase_d = PH_PC;
      end
      S_PC: begin
        tx_data_d  = 8'(data_pc_debug_i);
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_SETTLE: begin
        // Debug address has been stable for two cycles when captured.
        if (!hold_q) begin
          hold_d = 1'b1;
        end else begin
          hold_d     = 1'b0;
          word_d     = cap;
          tx_data_d  = cap[NB_DATA-1 -: 8];
          tx_start_d = 1'b1;
          byte_d     = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if (phase_q == PH_PC) begin
            phase_d    = PH_REG;
            sel_reg_d  = 1'b1;
            addr_reg_d = '0;
            state_d    = S_SETTLE;
          end else if (byte_q != 2'd3) begin
            byte_d     = byte_q + 2'd1;
            tx_data_d  = word_q[NB_DATA-9 -: 8];
            word_d     = word_q << 8;
            tx_start_d = 1'b1;
          end else if (phase_q == PH_REG) begin
            state_d = S_SETTLE;
            if (addr_reg_q == LAST_REG) begin
              phase_d    = PH_MEM;
              sel_reg_d  = 1'b0;
              sel_mem_d  = 1'b1;
              addr_mem_d = '0;
            end else begin
              addr_reg_d = addr_reg_q + R_ONE;
            end
          end else begin
            if (addr_mem_q == LAST_MEM) begin
              sel_mem_d = 1'b0;
              state_d   = S_IDLE;
            end else begin
              addr_mem_d = addr_mem_q + A_ONE;
              state_d    = S_SETTLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_read_d = (state_d != S_LOAD) && (state_d != S_WRITE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_PC;
      halted_q     <= 1'b0;
      byte_q       <= '0;
      hold_q       <= 1'b0;
      word_q       <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      en_pipe_q    <= 1'b0;
      en_read_q    <= 1'b0;
      inst_data_q  <= '0;
      inst_write_q <= 1'b0;
      inst_addr_q  <= '0;
      sel_reg_q    <= 1'b0;
      addr_reg_q   <= '0;
      sel_mem_q    <= 1'b0;
      addr_mem_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      halted_q     <= halted_d;
      byte_q       <= byte_d;
      hold_q       <= hold_d;
      word_q       <= word_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      en_pipe_q    <= en_pipe_d;
      en_read_q    <= en_read_d;
      inst_data_q  <= inst_data_d;
      inst_write_q <= inst_write_d;
      inst_addr_q  <= inst_addr_d;
      sel_reg_q    <= sel_reg_d;
      addr_reg_q   <= addr_reg_d;
      sel_mem_q    <= sel_mem_d;
      addr_mem_q   <= addr_mem_d;
    end
  end

  assign tx_data_o                    = tx_data_q;
  assign tx_start_o                   = tx_start_q;
  assign en_pipeline_o                = en_pipe_q;
  assign en_read_inst_o               = en_read_q;
  assign inst_data_o                  = inst_data_q;
  assign inst_write_o                 = inst_write_q;
  assign inst_addr_o                  = inst_addr_q;
  assign select_debug_or_wireA_o      = sel_reg_q;
  assign addr_reg_debug_o             = addr_reg_q;
  assign select_debug_or_alu_result_o = sel_mem_q;
  assign addr_mem_debug_o             = addr_mem_q;
  assign state_o                      = state_q;

endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: UART-side stimulus, register/memory models
// and a scoreboard of expected TX bytes and instruction writes.
module tb_debug_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_i;
  logic        rx_done_i;
  logic        tx_done_i;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        halt_signal_i;
  logic [6:0]  pc;
  logic [31:0] data_registers_debug_i;
  logic [31:0] data_mem_debug_i;
  logic        en_pipeline_o;
  logic        en_read_inst_o;
  logic [31:0] inst_data_o;
  logic        inst_write_o;
  logic [6:0]  inst_addr_o;
  logic        sel_a;
  logic [4:0]  addr_reg;
  logic        sel_b;
  logic [6:0]  addr_mem;
  logic [3:0]  state_o;

  always #5 clock = ~clock;

  debug_unit dut (
    .clock                        (clock),
    .reset                        (reset),
    .rx_data_i                    (rx_data_i),
    .rx_done_i                    (rx_done_i),
    .tx_done_i                    (tx_done_i),
    .tx_data_o                    (tx_data_o),
    .tx_start_o                   (tx_start_o),
    .halt_signal_i                (halt_signal_i),
    .data_pc_debug_i              (pc),
    .data_registers_debug_i       (data_registers_debug_i),
    .data_mem_debug_i             (data_mem_debug_i),
    .en_pipeline_o                (en_pipeline_o),
    .en_read_inst_o               (en_read_inst_o),
    .inst_data_o                  (inst_data_o),
    .inst_write_o                 (inst_write_o),
    .inst_addr_o                  (inst_addr_o),
    .select_debug_or_wireA_o      (sel_a),
    .addr_reg_debug_o             (addr_reg),
    .select_debug_or_alu_result_o (sel_b),
    .addr_mem_debug_o             (addr_mem),
    .state_o                      (state_o)
  );

  function automatic logic [31:0] mem_val(int j);
    return 32'hC0DE_0000 + 32'(j) * 32'h0001_0101;
  endfunction

  // Register file r[i] = i, combinational; data memory synchronous.
  assign data_registers_debug_i = sel_a ? {27'd0, addr_reg} : 32'hBAD0_BAD0;
  logic [31:0] mem_rd = 32'd0;
  always @(posedge clock) mem_rd <= sel_b ? mem_val(int'(addr_mem)) : 32'hBAD1_BAD1;
  assign data_mem_debug_i = mem_rd;

  logic [7:0]  exp_tx[$];
  logic [38:0] exp_wr[$];
  int checks = 0, errors = 0;
  int tx_cnt = 0, en_cnt = 0, wr_cnt = 0;
  logic tx_prev = 1'b0, wr_prev = 1'b0;

  task automatic chk(string name, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (en_pipeline_o) en_cnt++;
      chk("en_with_select", 96'(en_pipeline_o & (sel_a | sel_b)), 96'(0));
      chk("tx_start_width", 96'(tx_start_o & tx_prev), 96'(0));
      chk("wr_width", 96'(inst_write_o & wr_prev), 96'(0));
      if (tx_start_o) begin
        tx_cnt++;
        chk("tx_expected", 96'(exp_tx.size() > 0), 96'(1));
        if (exp_tx.size() > 0) chk("tx_byte", 96'(tx_data_o), 96'(exp_tx.pop_front()));
      end
      if (inst_write_o) begin
        wr_cnt++;
        chk("wr_expected", 96'(exp_wr.size() > 0), 96'(1));
        if (exp_wr.size() > 0) chk("inst_write", 96'({inst_addr_o, inst_data_o}), 96'(exp_wr.pop_front()));
        chk("en_read_in_load", 96'(en_read_inst_o), 96'(0));
      end
    end
    tx_prev = tx_start_o;
    wr_prev = inst_write_o;
  end

  // UART TX side: finish each byte a few cycles after its start pulse.
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_start_o) begin
        repeat (2) @(negedge clock);
        tx_done_i = 1'b1;
        @(posedge clock);
        #1 tx_done_i = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic send(logic [7:0] b);
    @(negedge clock);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(negedge clock);
    rx_done_i = 1'b0;
  endtask

  task automatic send_gap(logic [7:0] b);
    send(b);
    repeat (2) @(negedge clock);
  endtask

  task automatic send_word(logic [31:0] w);
    send_gap(w[31:24]);
    send_gap(w[23:16]);
    send_gap(w[15:8]);
    send_gap(w[7:0]);
  endtask

  task automatic push_dump();
    logic [31:0] w;
    exp_tx.push_back({1'b0, pc});
    for (int i = 0; i < 32; i++) begin
      w = 32'(i);
      for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
    end
    for (int j = 0; j < 32; j++) begin
      w = mem_val(j);
      for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic wait_dump(string name, int target);
    int n = 0;
    while ((tx_cnt < target || state_o != 4'd0) && n < 6000) begin
      @(negedge clock);
      n++;
    end
    chk(name, 96'(tx_cnt), 96'(target));
    chk({name, "_left"}, 96'(exp_tx.size()), 96'(0));
  endtask

  task automatic chk_all_zero(string name);
    chk(name, {27'd0, tx_data_o, tx_start_o, en_pipeline_o, en_read_inst_o,
               inst_data_o, inst_write_o, inst_addr_o, sel_a, addr_reg,
               sel_b, addr_mem, state_o}, 96'(0));
  endtask

  initial begin
    int t0, e0, w0, n;
    logic [31:0] w;
    reset = 1'b1;
    rx_data_i = 8'h00;
    rx_done_i = 1'b0;
    halt_signal_i = 1'b0;
    pc = 7'h00;
    #1 chk_all_zero("reset_outputs");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_en_read", 96'(en_read_inst_o), 96'(1));
    chk("idle_state", 96'(state_o), 96'(0));

    // Load a two-word program.
    exp_wr.push_back({7'd0, 32'h2001_0005});
    exp_wr.push_back({7'd1, 32'hFFFF_FFFF});
    send_gap(8'h4C);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    chk("load1_writes", 96'(wr_cnt), 96'(2));
    chk("load1_state", 96'(state_o), 96'(0));
    chk("load1_en_pipe", 96'(en_pipeline_o), 96'(0));
    chk("load1_en_read", 96'(en_read_inst_o), 96'(1));

    // Continuous run halted after 10 enabled cycles.
    pc = 7'h2A;
    push_dump();
    chk("model_len", 96'(exp_tx.size()), 96'(257));
    chk("model_pc", 96'(exp_tx[0]), 96'(8'h2A));
    chk("model_r31", 96'(exp_tx[128]), 96'(8'h1F));
    chk("model_m0", 96'(exp_tx[129]), 96'(8'hC0));
    chk("model_m31", 96'(exp_tx[256]), 96'(8'h1F));
    t0 = tx_cnt;
    e0 = en_cnt;
    send(8'h43);
    repeat (9) @(negedge clock);
    halt_signal_i = 1'b1;
    @(negedge clock);
    halt_signal_i = 1'b0;
    wait_dump("run_dump", t0 + 257);
    chk("run_en_cycles", 96'(en_cnt - e0), 96'(10));

    // Halted: steps ignored until a reload.
    e0 = en_cnt;
    t0 = tx_cnt;
    send_gap(8'h53);
    repeat (40) @(negedge clock);
    chk("halted_en", 96'(en_cnt - e0), 96'(0));
    chk("halted_tx", 96'(tx_cnt - t0), 96'(0));

    exp_wr.push_back({7'd0, 32'h0000_0013});
    exp_wr.push_back({7'd1, 32'hFFFF_FFFF});
    send_gap(8'h4C);
    send_word(32'h0000_0013);
    send_word(32'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    chk("load2_writes", 96'(wr_cnt), 96'(4));

    for (int k = 0; k < 3; k++) begin
      pc = 7'(k + 5);
      push_dump();
      t0 = tx_cnt;
      e0 = en_cnt;
      send(8'h53);
      wait_dump("step_dump", t0 + 257);
      chk("step_en", 96'(en_cnt - e0), 96'(1));
    end

    // Step that reaches halt, then everything but load is ignored.
    pc = 7'h7F;
    push_dump();
    chk("model_pc7f", 96'(exp_tx[0]), 96'(8'h7F));
    t0 = tx_cnt;
    e0 = en_cnt;
    halt_signal_i = 1'b1;
    send(8'h53);
    @(negedge clock);
    halt_signal_i = 1'b0;
    wait_dump("halt_step_dump", t0 + 257);
    chk("halt_step_en", 96'(en_cnt - e0), 96'(1));
    t0 = tx_cnt;
    e0 = en_cnt;
    send_gap(8'h53);
    send_gap(8'h43);
    tx_done_i = 1'b1;
    @(negedge clock);
    tx_done_i = 1'b0;
    repeat (40) @(negedge clock);
    chk("after_halt_en", 96'(en_cnt - e0), 96'(0));
    chk("after_halt_tx", 96'(tx_cnt - t0), 96'(0));

    // 130-word load: only 0..127 written, trailing bytes are commands.
    w0 = wr_cnt;
    for (int k = 0; k < 128; k++) exp_wr.push_back({7'(k), 8'h10, 8'(k), 8'h5A, 8'hA5});
    chk("model_wr_len", 96'(exp_wr.size()), 96'(128));
    send_gap(8'h4C);
    for (int k = 0; k < 128; k++) begin
      w = {8'h10, 8'(k), 8'h5A, 8'hA5};
      send_word(w);
    end
    chk("full_load_writes", 96'(wr_cnt - w0), 96'(128));
    chk("full_load_addr", 96'(inst_addr_o), 96'(7'h7F));
    chk("full_load_state", 96'(state_o), 96'(0));
    send_word(32'h1122_3344);
    send_gap(8'h55);
    send_gap(8'h66);
    send_gap(8'h77);
    pc = 7'h33;
    push_dump();
    t0 = tx_cnt;
    e0 = en_cnt;
    send(8'h53);
    wait_dump("tail_step_dump", t0 + 257);
    chk("tail_step_en", 96'(en_cnt - e0), 96'(1));
    chk("tail_no_write", 96'(wr_cnt - w0), 96'(128));

    // Reset in the middle of a dump (step also sets halted).
    pc = 7'h11;
    push_dump();
    t0 = tx_cnt;
    halt_signal_i = 1'b1;
    send(8'h53);
    @(negedge clock);
    halt_signal_i = 1'b0;
    n = 0;
    while (tx_cnt < t0 + 40 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("mid_dump_bytes", 96'(tx_cnt - t0), 96'(40));
    reset = 1'b1;
    #1 chk_all_zero("mid_dump_reset");
    exp_tx.delete();
    @(negedge clock);
    reset = 1'b0;
    t0 = tx_cnt;
    e0 = en_cnt;
    repeat (40) @(negedge clock);
    chk("post_reset_tx", 96'(tx_cnt - t0), 96'(0));
    chk("post_reset_en", 96'(en_cnt - e0), 96'(0));
    chk("post_reset_state", 96'(state_o), 96'(0));
    pc = 7'h04;
    push_dump();
    t0 = tx_cnt;
    send(8'h53);
    wait_dump("post_reset_step", t0 + 257);
    chk("post_reset_step_en", 96'(en_cnt - e0), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
